seven_led_scan_n: RTL and testbench
===================================

Name: seven_led_scan_n

Overview:
- Parametrised multiplexed seven-segment driver for a common-anode display with N digits. It replaces fixed 4-digit scanning on i_clock (56.84 MHz).
- Adds a writable per-digit register file, full hex font, and per-digit decimal point, blank and blink.
- Adds a brightness PWM, an anti-ghosting guard and a frame strobe.
- Status logic such as load/save mode indicators writes digits through a simple strobe interface.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 56840, i_clock cycles per digit slot (default: 1 kHz slot rate, 250 Hz refresh at 4 digits); must be > GUARD + 2^BRIGHT_W
GUARD, 64, cycles at the start of each slot with all digits off (anti-ghosting)
BRIGHT_W, 3, brightness code width
BLINK_FRAMES, 128, full scan frames per blink half-period
IDX_W, 2, digit index width; must satisfy 2^IDX_W >= DIGITS

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_wr  in  1  write strobe, one cycle
i_wr_idx  in  IDX_W  digit to write; 0 = rightmost (o_dig[0])
i_wr_data  in  8  [3:0] hex code, [4] dp on, [5] blank, [6] blink enable, [7] reserved (stored, ignored)
i_bright  in  BRIGHT_W  brightness code; on-time = (code+1)/2^BRIGHT_W of the usable slot
o_seg  out  8  segments, active-low; [6:0] = g..a, [7] = dp
o_dig  out  DIGITS  digit enables, active-low, at most one low
o_frame  out  1  one-cycle pulse when the slot for digit 0 begins

Behaviour:
- Reset (asynchronous, active-high):
  - o_seg = 8'hFF, o_dig = all ones, o_frame = 0.
  - slot_cnt, digit index, frame counter and blink phase are cleared to 0.
  - Every digit register is set to 8'h20 (blank).
  - Reset mid-slot drops the outputs immediately.
- Slot counter:
  - slot_cnt runs 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances to the next digit; DIGITS-1 wraps to 0.
- Slot start (cycle where slot_cnt = 0):
  - The current digit's register is latched into a snapshot.
  - i_bright is latched, and ON = ((SCAN_DIV-GUARD) >> BRIGHT_W) * (code+1) is computed.
  - Register changes and i_bright changes take effect only at the next slot start. There are no mid-slot glitches.
- Digit enable: the digit is driven when GUARD <= slot_cnt < GUARD+ON. Otherwise o_dig is all ones and o_seg = 8'hFF.
- Outputs are registered, so they lag slot_cnt by exactly one cycle.
- Font (hex, active-low):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
  - dp on clears bit 7.
- Display precedence:
  - blank = 1 → o_seg = FF while the digit is still enabled.
  - blink = 1 and blink phase = 1 → shown as blank.
- Blink phase: the frame counter increments each time the digit index wraps to 0. After BLINK_FRAMES frames, the counter clears and the phase toggles.
- o_frame is high for one output cycle, aligned with output slot_cnt = 0 of digit 0.
- Writes:
  - i_wr stores i_wr_data in register i_wr_idx at the clock edge.
  - A write with i_wr_idx >= DIGITS is ignored.
  - A write in the same cycle as that digit's slot-start snapshot is written through: the new value is displayed in that slot.
  - Back-to-back writes are all accepted; the last one wins.

Test Plan (DIGITS=4, SCAN_DIV=16, GUARD=2, BRIGHT_W=2, BLINK_FRAMES=2, IDX_W=2):
- Reset, no writes, i_bright=3 → o_seg=FF on every cycle. o_dig low 12 cycles per slot (output cycles 3..14 after slot start), all ones otherwise. o_frame pulses every 64 cycles.
- Write idx0=0x00, idx1=0x11, idx2=0x0D, idx3=0x0F → digit0 shows C0, digit1 shows 79, digit2 shows A1, digit3 shows 8E, each only while its own o_dig bit is low.
- i_bright=0 → each digit low for exactly 3 cycles per slot. Change i_bright mid-slot to 3 → the current slot keeps 3 cycles; the next slot shows 12.
- Write idx2=0x48 (blink, '8') → digit2 shows 80 for 2 frames (128 cycles), then FF for 2 frames, repeating.
- Write idx=3 with 0x05 in the exact cycle digit3's slot starts → that same slot shows 92. A write with idx≥DIGITS at DIGITS=3 leaves all registers unchanged.
- Assert i_reset mid-slot with digit1 lit → o_dig=all ones and o_seg=FF immediately. After release, scanning restarts at digit0 with all digits blank.

Source files
------------

// File: rtl/seven_led_scan_n.sv
// Multiplexed common-anode seven-segment scanner: per-digit register file, hex font,
// decimal point, blank/blink, brightness PWM, anti-ghosting guard and a frame strobe.
module seven_led_scan_n #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 56840,
    parameter int unsigned GUARD        = 64,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 128,
    parameter int unsigned IDX_W        = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [7:0]          i_wr_data,
    input  logic [BRIGHT_W-1:0] i_bright,
    output logic [7:0]          o_seg,
    output logic [DIGITS-1:0]   o_dig,
    output logic                o_frame
);
    localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
    localparam int unsigned ON_W    = SLOT_W + 1;
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned ON_UNIT = (SCAN_DIV - GUARD) >> BRIGHT_W;

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [IDX_W-1:0]   r_dig_idx;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_blink_phase;
    logic [7:0]         r_digit [DIGITS];
    logic [7:0]         r_snap;
    logic [ON_W-1:0]    r_on;
    logic [7:0]         r_seg;
    logic [DIGITS-1:0]  r_dig;
    logic               r_frame;

    logic              w_slot_start;
    logic              w_slot_end;
    logic              w_frame_end;
    logic [DIGITS-1:0] w_wr_hit;
    logic [7:0]        w_cur;
    logic [7:0]        w_snap;
    logic [7:0]        w_font;
    logic [7:0]        w_seg_next;
    logic [DIGITS-1:0] w_dig_next;
    logic [ON_W-1:0]   w_on_calc;
    logic [ON_W-1:0]   w_on;
    logic [ON_W-1:0]   w_pos;
    logic              w_lit;
    logic              w_blanked;

    assign w_slot_start = (r_slot_cnt == '0);
    assign w_slot_end   = (r_slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign w_frame_end  = w_slot_end && (r_dig_idx == IDX_W'(DIGITS - 1));

    // Write decode; indices >= DIGITS match no entry and are dropped.
    always_comb begin
        w_wr_hit = '0;
        w_cur    = r_digit[0];
        for (int k = 0; k < int'(DIGITS); k++) begin
            w_wr_hit[k] = i_wr && (i_wr_idx == IDX_W'(k));
            if (r_dig_idx == IDX_W'(k)) begin
                w_cur = r_digit[k];
            end
        end
        if (i_wr && (i_wr_idx == r_dig_idx)) begin
            w_cur = i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                r_digit[k] <= 8'h20;
            end
        end else begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                if (w_wr_hit[k]) begin
                    r_digit[k] <= i_wr_data;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_slot_cnt    <= '0;
            r_dig_idx     <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= w_frame_end ? '0 : r_dig_idx + 1'b1;
            if (w_frame_end) begin
                if (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    assign w_on_calc = ON_W'(ON_UNIT * (32'(i_bright) + 32'd1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_snap <= 8'h20;
            r_on   <= '0;
        end else if (w_slot_start) begin
            r_snap <= w_cur;
            r_on   <= w_on_calc;
        end
    end

    // During the slot-start cycle the snapshot is still being loaded, so bypass it.
    assign w_snap = w_slot_start ? w_cur : r_snap;
    assign w_on   = w_slot_start ? w_on_calc : r_on;
    assign w_pos  = {1'b0, r_slot_cnt};
    assign w_lit  = (w_pos >= ON_W'(GUARD)) && (w_pos < ON_W'(GUARD) + w_on);

    always_comb begin
        w_font = 8'hFF;
        unique case (w_snap[3:0])
            4'h0: w_font = 8'hC0;
            4'h1: w_font = 8'hF9;
            4'h2: w_font = 8'hA4;
            4'h3: w_font = 8'hB0;
            4'h4: w_font = 8'h99;
            4'h5: w_font = 8'h92;
            4'h6: w_font = 8'h82;
            4'h7: w_font = 8'hF8;
            4'h8: w_font = 8'h80;
            4'h9: w_font = 8'h90;
            4'hA: w_font = 8'h88;
            4'hB: w_font = 8'h83;
            4'hC: w_font = 8'hC6;
            4'hD: w_font = 8'hA1;
            4'hE: w_font = 8'h86;
            4'hF: w_font = 8'h8E;
            default: w_font = 8'hFF;
        endcase
    end

    assign w_blanked = w_snap[5] || (w_snap[6] && r_blink_phase);

    always_comb begin
        w_seg_next = 8'hFF;
        w_dig_next = '1;
        if (w_lit) begin
            w_dig_next = ~(DIGITS'(1) << r_dig_idx);
            if (!w_blanked) begin
                w_seg_next = {~w_snap[4], w_font[6:0]};
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_seg   <= 8'hFF;
            r_dig   <= '1;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_next;
            r_dig   <= w_dig_next;
            r_frame <= w_slot_start && (r_dig_idx == '0);
        end
    end

    assign o_seg   = r_seg;
    assign o_dig   = r_dig;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_seven_led_scan_n.sv
// Bench for seven_led_scan_n: a 4-digit and a 3-digit instance share all inputs and are
// compared every cycle against a time-indexed model of the scan schedule.
module tb_seven_led_scan_n;
    localparam int S  = 16;
    localparam int G  = 2;
    localparam int BW = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] bright = 2'd3;

    logic [7:0] seg4;
    logic [3:0] dig4;
    logic       frame4;
    logic [7:0] seg3;
    logic [2:0] dig3;
    logic       frame3;

    always #5 clk = ~clk;

    seven_led_scan_n #(
        .DIGITS(4), .SCAN_DIV(S), .GUARD(G), .BRIGHT_W(BW), .BLINK_FRAMES(BF), .IDX_W(2)
    ) u_dut4 (
        .i_clock(clk), .i_reset(rst), .i_wr(wr), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
        .i_bright(bright), .o_seg(seg4), .o_dig(dig4), .o_frame(frame4)
    );

    seven_led_scan_n #(
        .DIGITS(3), .SCAN_DIV(S), .GUARD(G), .BRIGHT_W(BW), .BLINK_FRAMES(BF), .IDX_W(2)
    ) u_dut3 (
        .i_clock(clk), .i_reset(rst), .i_wr(wr), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
        .i_bright(bright), .o_seg(seg3), .o_dig(dig3), .o_frame(frame3)
    );

    int errors = 0;
    int checks = 0;

    // Model state; index 0 is the 4-digit instance, index 1 the 3-digit one.
    int unsigned m_t [2];
    logic [7:0]  m_regs [2][4];
    logic [7:0]  m_snap [2];
    int          m_on [2];
    logic [7:0]  e_seg [2];
    logic [7:0]  e_dig [2];
    logic        e_frame [2];
    logic [7:0]  font [16];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0;
            for (int i = 0; i < 4; i++) m_regs[k][i] = 8'h20;
            m_snap[k]  = 8'h20;
            m_on[k]    = 0;
            e_seg[k]   = 8'hFF;
            e_dig[k]   = 8'hFF;
            e_frame[k] = 1'b0;
        end
    endtask

    // One clock edge of the display schedule, derived from elapsed cycles since reset.
    task automatic model_edge(input int k);
        int d   = (k == 0) ? 4 : 3;
        int pos = int'(m_t[k] % S);
        int dg  = int'((m_t[k] / S) % d);
        int fr  = int'(m_t[k] / (S * d));
        bit ph  = ((fr / BF) % 2) == 1;
        bit lit;
        logic [7:0] f;
        if (pos == 0) begin
            m_snap[k] = (wr && int'(wr_idx) == dg) ? wr_data : m_regs[k][dg];
            m_on[k]   = ((S - G) >> BW) * (int'(bright) + 1);
        end
        lit = (pos >= G) && (pos < G + m_on[k]);
        e_dig[k]   = lit ? (8'hFF & ~(8'd1 << dg)) : 8'hFF;
        f          = font[m_snap[k][3:0]];
        if (!lit || m_snap[k][5] || (m_snap[k][6] && ph)) e_seg[k] = 8'hFF;
        else e_seg[k] = {~m_snap[k][4], f[6:0]};
        e_frame[k] = (pos == 0) && (dg == 0);
        if (wr && int'(wr_idx) < d) m_regs[k][wr_idx] = wr_data;
        m_t[k]++;
    endtask

    task automatic tick();
        logic [7:0] ed;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        chk("seg4", seg4, e_seg[0]);
        ed = e_dig[0];
        chk("dig4", {4'h0, dig4}, {4'h0, ed[3:0]});
        chk("frame4", {7'd0, frame4}, {7'd0, e_frame[0]});
        chk("seg3", seg3, e_seg[1]);
        ed = e_dig[1];
        chk("dig3", {5'd0, dig3}, {5'd0, ed[2:0]});
        chk("frame3", {7'd0, frame3}, {7'd0, e_frame[1]});
    endtask

    task automatic write(input logic [1:0] idx, input logic [7:0] data);
        wr = 1'b1;
        wr_idx = idx;
        wr_data = data;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        int n;
        int hits;
        font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // All digits blank: scan timing and frame strobe only.
        for (int i = 0; i < 140; i++) tick();

        write(2'd0, 8'h00);
        write(2'd1, 8'h11);
        write(2'd2, 8'h0D);
        write(2'd3, 8'h0F);
        for (int i = 0; i < 140; i++) tick();

        // Minimum brightness, then a mid-slot change back to full.
        bright = 2'd0;
        for (int i = 0; i < 71; i++) tick();
        bright = 2'd3;
        for (int i = 0; i < 70; i++) tick();

        write(2'd2, 8'h48);
        for (int i = 0; i < 330; i++) tick();

        // Write-through on digit 3's slot start; idx 3 is also out of range for the 3-digit part.
        n = 0;
        while (!((m_t[0] % S) == 0 && ((m_t[0] / S) % 4) == 3) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_slot3", {7'd0, n < 200}, 8'd1);
        write(2'd3, 8'h05);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dig4 == 4'b0111 && seg4 == 8'h92) hits++;
        end
        chk("writethru_cycles", 8'(hits), 8'd12);
        for (int i = 0; i < 80; i++) tick();

        // Random writes and brightness changes.
        for (int i = 0; i < 600; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            wr_idx = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bright = 2'($urandom_range(0, 3));
            tick();
        end
        wr = 1'b0;
        bright = 2'd3;

        // Asynchronous reset while digit 1 is lit.
        n = 0;
        while (e_dig[0] != 8'hFD && n < 200) begin
            tick();
            n++;
        end
        chk("wait_dig1", {7'd0, n < 200}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_seg4", seg4, 8'hFF);
        chk("rst_dig4", {4'h0, dig4}, 8'h0F);
        chk("rst_seg3", seg3, 8'hFF);
        chk("rst_dig3", {5'd0, dig3}, 8'h07);
        model_reset();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 140; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
